// File: rtl/draw_sequencer.sv
// ============================================================================
// Module   : draw_sequencer
// Brief    : Sequences a clear pass then a shape pass, muxes the active engine
//            onto the VGA adapter port, clips shape pixels, counts plots.
// Revision : 1.0
// ============================================================================
`default_nettype none

module draw_sequencer #(
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 120,
    parameter bit AUTO_START = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        clr_start,
    input  logic        clr_done,
    input  logic [7:0]  clr_x,
    input  logic [6:0]  clr_y,
    input  logic [2:0]  clr_colour,
    input  logic        clr_plot,
    output logic        shp_start,
    input  logic        shp_done,
    input  logic [7:0]  shp_x,
    input  logic [6:0]  shp_y,
    input  logic [2:0]  shp_colour,
    input  logic        shp_plot,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic        busy,
    output logic        done,
    output logic [14:0] pix_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_DRAW  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [14:0] c_PIX_MAX = 15'h7FFF;

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic        r_auto;
    logic        r_clr_start;
    logic        r_shp_start;
    logic [14:0] r_pix_count;
    logic        w_shp_visible;

    assign w_shp_visible = (int'(shp_x) < SCREEN_W) && (int'(shp_y) < SCREEN_H);

    // r_auto is armed by reset and consumed on the first free-running cycle,
    // so the automatic trigger fires exactly once per reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_auto      <= AUTO_START;
            r_clr_start <= 1'b0;
            r_shp_start <= 1'b0;
            r_pix_count <= '0;
        end else begin
            r_state     <= w_next;
            r_auto      <= 1'b0;
            r_clr_start <= (w_next == S_CLEAR);
            r_shp_start <= (w_next == S_DRAW);
            if (r_state == S_GAP) begin
                r_pix_count <= '0;
            end else if ((r_state == S_DRAW) && vga_plot && (r_pix_count != c_PIX_MAX)) begin
                r_pix_count <= r_pix_count + 15'd1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start || r_auto) w_next = S_CLEAR;
            S_CLEAR: if (clr_done)        w_next = S_GAP;
            S_GAP:                        w_next = S_DRAW;
            S_DRAW:  if (shp_done)        w_next = S_DONE;
            S_DONE:  if (!start)          w_next = S_IDLE;
            default:                      w_next = S_IDLE;
        endcase
    end

    // Zero-latency mux keeps each engine's own pixel timing intact.
    always_comb begin
        vga_x      = shp_x;
        vga_y      = shp_y;
        vga_colour = shp_colour;
        vga_plot   = 1'b0;
        if (r_state == S_CLEAR) begin
            vga_x      = clr_x;
            vga_y      = clr_y;
            vga_colour = clr_colour;
            vga_plot   = clr_plot & ~rst;
        end else if (r_state == S_DRAW) begin
            vga_plot   = shp_plot & w_shp_visible & ~rst;
        end
    end

    assign busy      = (r_state == S_CLEAR) || (r_state == S_GAP) || (r_state == S_DRAW);
    assign done      = (r_state == S_DONE);
    assign clr_start = r_clr_start;
    assign shp_start = r_shp_start;
    assign pix_count = r_pix_count;

endmodule

`default_nettype wire

// File: tb/tb_draw_sequencer.sv
// ============================================================================
// Module   : tb_draw_sequencer
// Brief    : Directed bench for draw_sequencer, auto-start and manual instances.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_draw_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_m, start;
    logic clr_done, clr_plot, shp_done, shp_plot;
    logic [7:0] clr_x, shp_x;
    logic [6:0] clr_y, shp_y;
    logic [2:0] clr_colour, shp_colour;

    logic a_clr_start, a_shp_start, a_plot, a_busy, a_done;
    logic [7:0] a_x;
    logic [6:0] a_y;
    logic [2:0] a_col;
    logic [14:0] a_cnt;
    logic m_clr_start, m_shp_start, m_plot, m_busy, m_done;
    logic [7:0] m_x;
    logic [6:0] m_y;
    logic [2:0] m_col;
    logic [14:0] m_cnt;

    draw_sequencer #(.SCREEN_W(160), .SCREEN_H(120), .AUTO_START(1'b1)) u_auto (
        .clk(clk), .rst(rst_a), .start(start),
        .clr_start(a_clr_start), .clr_done(clr_done), .clr_x(clr_x), .clr_y(clr_y),
        .clr_colour(clr_colour), .clr_plot(clr_plot),
        .shp_start(a_shp_start), .shp_done(shp_done), .shp_x(shp_x), .shp_y(shp_y),
        .shp_colour(shp_colour), .shp_plot(shp_plot),
        .vga_x(a_x), .vga_y(a_y), .vga_colour(a_col), .vga_plot(a_plot),
        .busy(a_busy), .done(a_done), .pix_count(a_cnt)
    );

    draw_sequencer #(.SCREEN_W(160), .SCREEN_H(120), .AUTO_START(1'b0)) u_man (
        .clk(clk), .rst(rst_m), .start(start),
        .clr_start(m_clr_start), .clr_done(clr_done), .clr_x(clr_x), .clr_y(clr_y),
        .clr_colour(clr_colour), .clr_plot(clr_plot),
        .shp_start(m_shp_start), .shp_done(shp_done), .shp_x(shp_x), .shp_y(shp_y),
        .shp_colour(shp_colour), .shp_plot(shp_plot),
        .vga_x(m_x), .vga_y(m_y), .vga_colour(m_col), .vga_plot(m_plot),
        .busy(m_busy), .done(m_done), .pix_count(m_cnt)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr_done = 0; clr_plot = 0; clr_x = 0; clr_y = 0; clr_colour = 0;
        shp_done = 0; shp_plot = 0; shp_x = 0; shp_y = 0; shp_colour = 0;
    endtask

    logic [7:0] vx [5] = '{8'd159, 8'd160, 8'd80, 8'd80, 8'd255};
    logic [6:0] vy [5] = '{7'd60, 7'd60, 7'd119, 7'd120, 7'd127};
    logic       vp [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    int plots;

    initial begin
        idle_inputs();
        rst_a = 1; rst_m = 1; start = 0;
        clr_plot = 1;
        tick(); tick();
        #1;
        chk("rst_clr_start", a_clr_start, 0);
        chk("rst_shp_start", a_shp_start, 0);
        chk("rst_busy_done", {a_busy, a_done}, 0);
        chk("rst_pix_count", a_cnt, 0);
        chk("rst_vga_plot", a_plot, 0);

        // ---- auto-start: full 19200-pixel clear pass ----
        rst_a = 0;
        tick();
        chk("auto_clr_start", a_clr_start, 1);
        chk("auto_busy", a_busy, 1);
        plots = 0;
        for (int i = 0; i < 19200; i++) begin
            clr_x = 8'(i % 160); clr_y = 7'(i / 160); clr_colour = 3'(i % 8);
            clr_plot = 1; clr_done = (i == 19199);
            shp_done = (i == 5);
            #1;
            if (i == 6) chk("shp_done_in_clear", {a_clr_start, a_shp_start}, 2'b10);
            if (i == 19199) chk("clear_last_pix", {a_x, a_y, a_col, a_plot}, {8'd159, 7'd119, 3'd7, 1'b1});
            plots += int'(a_plot);
            tick();
        end
        chk("clear_plot_total", plots, 19200);
        idle_inputs();
        chk("gap_starts", {a_clr_start, a_shp_start, a_busy}, 3'b001);
        tick();
        chk("draw_shp_start", {a_clr_start, a_shp_start}, 2'b01);
        chk("draw_entry_count", a_cnt, 0);

        // ---- clipping vectors ----
        for (int k = 0; k < 5; k++) begin
            shp_x = vx[k]; shp_y = vy[k]; shp_colour = 3'(k); shp_plot = 1;
            #1;
            chk($sformatf("clip_plot_%0d", k), a_plot, vp[k]);
            chk($sformatf("clip_xy_%0d", k), {a_x, a_y}, {vx[k], vy[k]});
            tick();
        end
        shp_plot = 0; clr_done = 1;
        tick();
        clr_done = 0;
        chk("clr_done_in_draw", {a_shp_start, a_busy}, 2'b11);
        chk("count_after_clip", a_cnt, 2);

        // last pixel together with shp_done
        shp_x = 10; shp_y = 20; shp_colour = 5; shp_plot = 1; shp_done = 1;
        #1;
        chk("last_pix_fwd", {a_x, a_y, a_col, a_plot}, {8'd10, 7'd20, 3'd5, 1'b1});
        tick();
        idle_inputs();
        chk("done_state", {a_done, a_busy, a_shp_start}, 3'b100);
        chk("done_count", a_cnt, 3);
        tick();
        chk("auto_back_idle", {a_done, a_busy, a_clr_start}, 3'b000);
        tick();
        chk("auto_no_retrigger", a_clr_start, 0);

        // ---- reset mid-DRAW after 500 plotted pixels ----
        rst_a = 1; tick(); rst_a = 0; tick();
        chk("rerun_clear", a_clr_start, 1);
        clr_done = 1; tick(); clr_done = 0; tick();
        chk("rerun_draw", a_shp_start, 1);
        for (int i = 0; i < 500; i++) begin
            shp_x = 8'(i % 160); shp_y = 7'(i % 120); shp_plot = 1;
            tick();
        end
        chk("count_500", a_cnt, 500);
        rst_a = 1;
        tick();
        chk("midrst_state", {a_busy, a_done, a_shp_start, a_clr_start}, 4'b0000);
        chk("midrst_count", a_cnt, 0);
        chk("midrst_plot", a_plot, 0);
        rst_a = 0; shp_plot = 0;
        tick();
        chk("midrst_autorun", a_clr_start, 1);

        // ---- manual instance: AUTO_START=0 ----
        rst_a = 1; idle_inputs();
        rst_m = 0;
        tick(); tick();
        chk("man_no_auto", {m_busy, m_clr_start}, 2'b00);
        start = 1;
        tick();
        chk("man_clear", m_clr_start, 1);
        clr_done = 1; tick(); clr_done = 0; tick();
        chk("man_draw", m_shp_start, 1);
        for (int i = 0; i < 3; i++) begin
            shp_x = 8'(i); shp_y = 7'(i); shp_plot = 1;
            tick();
        end
        shp_plot = 0; shp_done = 1; tick(); shp_done = 0;
        chk("man_done", {m_done, m_cnt}, {1'b1, 15'd3});
        tick(); tick(); tick();
        chk("man_hold_done", {m_done, m_clr_start, m_busy}, 3'b100);
        start = 0;
        tick();
        chk("man_idle", {m_done, m_busy}, 2'b00);
        start = 1;
        tick();
        chk("man_retrigger", {m_clr_start, m_cnt}, {1'b1, 15'd3});
        clr_done = 1; tick(); clr_done = 0;
        chk("man_gap_holds_cnt", m_cnt, 3);
        tick();
        chk("man_draw_clears_cnt", {m_shp_start, m_cnt}, {1'b1, 15'd0});

        // saturation
        shp_x = 1; shp_y = 1; shp_plot = 1;
        for (int i = 0; i < 32770; i++) tick();
        chk("saturate", m_cnt, 32767);
        shp_plot = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/draw_sequencer.md
Name: draw_sequencer

Overview:
- Sits directly upstream of vga_adapter, between it and the two drawing engines.
- Engines: the full-screen fill engine (clear) and a shape engine (reuleaux/circle class).
- Runs a clear pass, then a shape pass, via start/done handshakes with each engine.
- Muxes the active engine's pixel stream onto the single adapter port, clips off-screen shape pixels, and counts the pixels actually plotted.

Parameters:
- SCREEN_W, 160, visible width; shape pixels with x >= SCREEN_W are dropped.
- SCREEN_H, 120, visible height; shape pixels with y >= SCREEN_H are dropped.
- AUTO_START, 1, 1 = leave IDLE on the first cycle after reset without needing start.

Ports:
- clk  in  1  system clock (CLOCK_50)
- rst  in  1  synchronous active-high reset
- start  in  1  level request to run clear then shape
- clr_start  out  1  start to fill engine
- clr_done  in  1  fill engine done
- clr_x  in  8  fill pixel x
- clr_y  in  7  fill pixel y
- clr_colour  in  3  fill colour
- clr_plot  in  1  fill plot strobe
- shp_start  out  1  start to shape engine
- shp_done  in  1  shape engine done
- shp_x  in  8  shape pixel x
- shp_y  in  7  shape pixel y
- shp_colour  in  3  shape colour
- shp_plot  in  1  shape plot strobe
- vga_x  out  8  to adapter
- vga_y  out  7  to adapter
- vga_colour  out  3  to adapter
- vga_plot  out  1  to adapter
- busy  out  1  high in CLEAR, GAP, DRAW
- done  out  1  high in DONE
- pix_count  out  15  shape pixels plotted this run, after clipping

Behaviour:
- One clock domain. Reset is synchronous and active-high, sampled on posedge clk. Reset has priority over everything.
- Reset values: state=IDLE, clr_start=0, shp_start=0, busy=0, done=0, pix_count=0.
- While in reset, vga_plot=0; vga_x/vga_y/vga_colour are don't-care.
- States: IDLE, CLEAR, GAP, DRAW, DONE. clr_start and shp_start are registered state decodes.
- IDLE:
  - Go to CLEAR when start=1, or on the first cycle after reset when AUTO_START=1.
  - The auto trigger fires once per reset only.
- CLEAR:
  - clr_start=1.
  - Go to GAP on the cycle clr_done=1 is sampled.
- GAP:
  - Exactly one cycle with both starts=0, so engines see start drop and re-arm.
  - Then go to DRAW.
- DRAW:
  - shp_start=1; pix_count cleared on entry (the GAP→DRAW edge).
  - Go to DONE on the cycle shp_done=1 is sampled.
- DONE:
  - Both starts=0, done=1; pix_count holds.
  - When start=0, go to IDLE. If start is still 1, stay in DONE; no re-trigger without a 0→1 level change through IDLE.
- Pixel mux (combinational, zero latency, so engine timing is preserved):
  - In CLEAR, vga_* = clr_*.
  - In DRAW, vga_x/y/colour = shp_*, and vga_plot = shp_plot & (shp_x < SCREEN_W) & (shp_y < SCREEN_H).
  - In all other states, vga_plot=0 and the vga_* data outputs are don't-care.
  - Clear pixels are not clipped.
- pix_count:
  - Increments on each cycle where DRAW and vga_plot=1.
  - Saturates at 32767 (no wrap).
- Simultaneous events:
  - If clr_done and clr_plot arrive in the same cycle, that pixel is still forwarded (mux uses the current state).
  - The same rule applies to shp_done with shp_plot; the last pixel is forwarded and counted.
- A done pulse asserted while not in the matching state is ignored (e.g. shp_done during CLEAR).
- Reset mid-operation returns to IDLE next cycle:
  - Both starts drop, vga_plot=0, pix_count=0.
  - With AUTO_START=1 the sequence reruns from CLEAR.

Test Plan:
- AUTO_START=1, rst high 2 cycles then low; fill engine model asserts clr_done after 19200 plots -> clr_start=1 from cycle 1 after reset, exactly one GAP cycle with both starts 0, then shp_start=1.
- In DRAW, shape model emits (159,60), (160,60), (80,119), (80,120), (255,127), each with plot=1 -> vga_plot=1 only for (159,60) and (80,119); pix_count=2 at DONE.
- shp_done asserted in the same cycle as the last in-bounds shp_plot -> pixel appears on vga_*, pix_count includes it, state=DONE next cycle with done=1.
- AUTO_START=0, start held 1 through DONE -> stays in DONE, no second CLEAR; drop start for 1 cycle and raise again -> IDLE then CLEAR, pix_count reset to 0 at the next DRAW entry.
- rst asserted mid-DRAW after 500 plotted pixels -> next cycle state=IDLE, pix_count=0, shp_start=0, vga_plot=0; with AUTO_START=1, clr_start=1 on the cycle after reset releases.
- shp_done pulsed during CLEAR and clr_done pulsed during DRAW -> no state change, counts unaffected.
